// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cpu ports, the arbiter and the single-ported memory.
// slave: arbiter view; master: cpu/memory side (driver of requests and mrdata).
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic [AW-1:0] iaddr;
    logic          ifetch;
    logic          igrant;
    logic [DW-1:0] idata;
    logic          ivalid;

    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dre;
    logic          dwe;
    logic          dgrant;
    logic [DW-1:0] drdata;
    logic          dvalid;

    logic [AW-1:0] maddr;
    logic          mre;
    logic          mwe;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;

    modport slave (
        input  iaddr, ifetch, daddr, dwdata, dre, dwe, mrdata,
        output igrant, idata, ivalid, dgrant, drdata, dvalid,
               maddr, mre, mwe, mwdata
    );

    modport master (
        output iaddr, ifetch, daddr, dwdata, dre, dwe, mrdata,
        input  igrant, idata, ivalid, dgrant, drdata, dvalid,
               maddr, mre, mwe, mwdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of the cpu fetch and data ports onto one memory port,
// steering the one-cycle read response back to the issuing port.
module mem_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic {LAST_I = 1'b0, LAST_D = 1'b1} last_e;

    last_e         last_q, last_d;
    logic          pend_q, pend_d;
    logic          who_q, who_d;
    logic [DW-1:0] idata_q, idata_d;
    logic [DW-1:0] drdata_q, drdata_d;

    logic          dreq;
    logic          gnt_i, gnt_d;
    logic          ivalid, dvalid;
    logic [AW-1:0] maddr_d;
    logic [DW-1:0] mwdata_d;
    logic          mre_d, mwe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= LAST_D;
            pend_q   <= 1'b0;
            who_q    <= 1'b0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            last_q   <= last_d;
            pend_q   <= pend_d;
            who_q    <= who_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        maddr_d  = '0;
        mwdata_d = '0;
        mre_d    = 1'b0;
        mwe_d    = 1'b0;
        last_d   = last_q;

        dreq  = bus.dre | bus.dwe;
        gnt_i = !rst && bus.ifetch && (!dreq || last_q == LAST_D);
        gnt_d = !rst && dreq && (!bus.ifetch || last_q == LAST_I);

        if (gnt_i) begin
            maddr_d = bus.iaddr;
            mre_d   = 1'b1;
            last_d  = LAST_I;
        end else if (gnt_d) begin
            maddr_d = bus.daddr;
            last_d  = LAST_D;
            // dwe dominates: a simultaneous dre is dropped, so no response is tagged
            if (bus.dwe) begin
                mwe_d    = 1'b1;
                mwdata_d = bus.dwdata;
            end else begin
                mre_d = 1'b1;
            end
        end

        pend_d = mre_d;
        who_d  = gnt_d;

        // A response tagged just before reset is suppressed while rst is high
        ivalid = pend_q && !who_q && !rst;
        dvalid = pend_q && who_q && !rst;

        idata_d  = ivalid ? bus.mrdata : idata_q;
        drdata_d = dvalid ? bus.mrdata : drdata_q;
    end

    assign bus.igrant = gnt_i;
    assign bus.dgrant = gnt_d;
    assign bus.ivalid = ivalid;
    assign bus.dvalid = dvalid;
    assign bus.idata  = idata_d;
    assign bus.drdata = drdata_d;
    assign bus.maddr  = maddr_d;
    assign bus.mre    = mre_d;
    assign bus.mwe    = mwe_d;
    assign bus.mwdata = mwdata_d;
endmodule
